debounce_ctrl: RTL
==================

Name: debounce_ctrl

Overview:
- Sequencing controller for a single-input debounce datapath.
- Registers the raw button level and runs an IDLE/COUNT state machine that clears, enables and terminates a tick-driven time counter.
- Publishes a debounced level plus one-cycle rise/fall pulses.
- Sits between the raw pin/button input and the downstream FSMs that consume clean button events.

Parameters:
- CNT_W, 6, width of the debounce time counter.
- DB_TICKS, 40, ticks the input must stay unchanged before acceptance; legal range 1 to 2^CNT_W-1.
- TICK_DIV, 1, clock cycles per counter tick; 1 means one tick per cycle.
- TICK_W, 16, prescaler width; TICK_DIV must be ≤ 2^TICK_W.
- RESET_VAL, 0, value of the debounced level after reset.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- btn_in, input, 1, raw button level.
- btn_stable, output, 1, debounced level.
- rise_pulse, output, 1, one-cycle pulse when btn_stable goes 0→1.
- fall_pulse, output, 1, one-cycle pulse when btn_stable goes 1→0.
- busy, output, 1, high while the FSM is in COUNT.

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset is synchronous, active-high, named reset.
  - Reset values: btn_stable=RESET_VAL, rise_pulse=0, fall_pulse=0, busy=0, state=IDLE, counter=0, prescaler=0, sample=RESET_VAL.
- Input sampling:
  - sample is btn_in registered once on every edge.
  - "Edge k" is the first edge at which sample captures a new value.
- IDLE state:
  - If sample==btn_stable: stay in IDLE; counter held at 0.
  - If sample!=btn_stable: go to COUNT and clear counter and prescaler. This occurs at edge k+1.
- COUNT state:
  - busy=1 (registered, reflects state).
  - Prescaler counts 0..TICK_DIV-1 and wraps; it generates a tick in the cycle where prescaler==TICK_DIV-1. With TICK_DIV=1, a tick is issued every cycle.
  - The counter increments by 1 on each tick.
  - Abort (highest priority): if sample==btn_stable, go to IDLE, clear counter, no pulse.
  - Finish: else if counter==DB_TICKS, then btn_stable<=sample, counter cleared, go to IDLE, and exactly one of rise_pulse/fall_pulse goes high for one cycle.
  - Abort wins over finish in the same cycle.
- Latency: btn_stable and the pulse update at edge k + 2 + DB_TICKS*TICK_DIV.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - It never wraps, because finish fires at DB_TICKS ≤ 2^CNT_W-1.
- Pulses: rise_pulse and fall_pulse are never high together and are never high in consecutive cycles. The minimum gap is 2 cycles.
- Reset mid-count: the counter is discarded, btn_stable returns to RESET_VAL, no pulse is emitted, and the FSM is in IDLE after the reset edge.
- Input already differing at reset release: the FSM enters COUNT on the first edge that samples the difference and follows the normal rules.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: two synchronizer flops are inserted ahead of sample. They reset to RESET_VAL. All latencies increase by 2 cycles.
- Undefined: single sample register only; btn_in is required to be synchronous to clk.

Decomposition:
- Shared package debounce_pkg:
  - State encoding localparams IDLE=2'b00, COUNT=2'b01.
  - Default constants DB_TICKS_DEF=40 and CNT_W_DEF=6.
- One natural sub-module: debounce_tick_timer.
  - Contains the prescaler and time counter.
  - Inputs: clear, enable.
  - Outputs: counter value, done (counter==DB_TICKS).
- debounce_ctrl owns the sampler, the FSM and the output registers.

Test Plan:
1. Reset with btn_in=0, held 3 cycles → btn_stable=0, pulses=0, busy=0 on every cycle after the reset edge; repeat with RESET_VAL=1 → btn_stable=1.
2. DB_TICKS=4, TICK_DIV=1; btn_in 0→1 and held; edge k is the first edge sampling the new value → busy=1 from k+1 to k+5; btn_stable=1 and rise_pulse=1 for exactly one cycle starting at edge k+6.
3. Bounce: btn_in=1 for 3 cycles, then 0, then 1 held → first attempt aborts with no pulse and busy drops; restart gives btn_stable=1 exactly 6 edges after the last edge that samples the new 1.
4. From stable=1, btn_in 1→0 held → fall_pulse for one cycle at k+6; rise_pulse stays 0 throughout.
5. TICK_DIV=3, DB_TICKS=4 → btn_stable updates at edge k+14; counter observed at 0,1,2,3,4 changing only every 3rd cycle.
6. Reset asserted while counter=2 → no pulse, btn_stable=RESET_VAL, IDLE next cycle.
   - With DEBOUNCE_SYNC_EN defined, re-run scenario 2 → update at edge k+8, where k is the first edge at which btn_in is sampled by the first synchronizer flop.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default constants for the debounce controller
package debounce_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] COUNT = 2'b01;
  localparam int DB_TICKS_DEF = 40;
  localparam int CNT_W_DEF = 6;
endpackage

// File: rtl/debounce_tick_timer.sv
// debounce_tick_timer: prescaled tick generator and saturating-at-target debounce time counter
module debounce_tick_timer
  import debounce_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DB_TICKS = DB_TICKS_DEF,
  parameter int TICK_DIV = 1,
  parameter int TICK_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done
);
  logic [TICK_W-1:0] r_pre;
  logic [CNT_W-1:0] r_cnt;
  logic w_tick;
  assign w_tick = r_pre == TICK_W'(TICK_DIV - 1);
  assign o_done = r_cnt == CNT_W'(DB_TICKS);
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (reset || i_clear) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (i_enable) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      r_cnt <= (w_tick && !o_done) ? r_cnt + 1'b1 : r_cnt;
    end
endmodule

// File: rtl/debounce_ctrl.sv
// debounce_ctrl: debounced button level with one-cycle rise/fall pulses
// DEBOUNCE_SYNC_EN inserts a two-flop synchronizer ahead of the sample register
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int   CNT_W = CNT_W_DEF,
  parameter int   DB_TICKS = 40,
  parameter int   TICK_DIV = 1,
  parameter int   TICK_W = 16,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_stable,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);
  logic r_sample, r_stable, r_rise, r_fall;
  logic [1:0] r_state, w_next;
  logic w_in, w_diff, w_done, w_finish, w_clear;
  logic [CNT_W-1:0] w_count;
`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk) r_sync <= reset ? {2{RESET_VAL}} : {r_sync[0], btn_in};
  assign w_in = r_sync[1];
`else
  assign w_in = btn_in;
`endif
  always_ff @(posedge clk) r_sample <= reset ? RESET_VAL : w_in;
  assign w_diff = r_sample != r_stable;
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb w_next = (r_state == IDLE) ? (w_diff ? COUNT : IDLE) : (!w_diff || w_done) ? IDLE : COUNT;
  always_comb begin
    busy = r_state == COUNT;
    w_finish = busy && w_diff && w_done;
    w_clear = !busy || !w_diff || w_done;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_stable <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      if (w_finish) r_stable <= r_sample;
      r_rise <= w_finish && r_sample;
      r_fall <= w_finish && !r_sample;
    end
  debounce_tick_timer #(
    .CNT_W(CNT_W),
    .DB_TICKS(DB_TICKS),
    .TICK_DIV(TICK_DIV),
    .TICK_W(TICK_W)
  ) u_timer (
    .clk(clk),
    .reset(reset),
    .i_clear(w_clear),
    .i_enable(busy),
    .o_count(w_count),
    .o_done(w_done)
  );
  // finish fires at DB_TICKS, so the counter can never pass it
  a_no_wrap: assert property (@(posedge clk) disable iff (reset) w_count <= CNT_W'(DB_TICKS));
  assign btn_stable = r_stable;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
endmodule
